// File: rtl/csr_pkg.sv
// Shared Zicsr encodings, FSM state type and well-known CSR addresses.
// Pure definitions: no latency, no backpressure.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_TWRITE
  } state_t;

  // funct3 000 and 100 have no CSR operation behind them
  function automatic logic f3_reserved(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

  // RW/RWI write unconditionally; set/clear forms only with a non-zero source index
  function automatic logic f3_wr_always(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write data path for Zicsr: write, set, clear.
// Combinational, zero latency, no backpressure.
module csr_rmw_alu #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] wdata
);

  always_comb begin
    case (op)
      2'b10:   wdata = old | src;
      2'b11:   wdata = old & ~src;
      default: wdata = src;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr ops as read/modify/write and arbitrates the CSR write port with the trap unit (trap wins).
// Core accept->rsp 2 cycles, trap accept->csr_we 1 cycle; both ready only while idle.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 12,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [4:0]        req_rs1_idx,
  input  logic              trap_valid,
  output logic              trap_ready,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic [XLEN-1:0]   trap_wdata,
  output logic [ADDR_W-1:0] csr_addrr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [ADDR_W-1:0] csr_addrw,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_we,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_illegal,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] op_addr;
  logic [XLEN-1:0]   op_src;
  logic [XLEN-1:0]   op_old;
  logic              op_wr_en;
  logic              idle, req_acc, trap_acc, ill;
  logic [XLEN-1:0]   alu_wdata;

  assign idle       = (state == ST_IDLE);
  assign trap_ready = idle;
  assign req_ready  = idle && !trap_valid;
  assign trap_acc   = trap_valid && idle;
  assign req_acc    = req_valid && req_ready;
  assign busy       = !idle;

  // read-only check only matters when the op would really write
  assign ill = f3_reserved(op_f3) ||
               (RO_CHECK && op_wr_en && (op_addr[ADDR_W-1 -: 2] == 2'b11));

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op    (op_f3[1:0]),
    .old   (op_old),
    .src   (op_src),
    .wdata (alu_wdata)
  );

  always_comb begin
    state_nxt   = state;
    csr_addrr   = '0;
    csr_addrw   = '0;
    csr_wdata   = '0;
    csr_we      = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_illegal = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trap_acc)     state_nxt = ST_TWRITE;
        else if (req_acc) state_nxt = ST_READ;
      end
      ST_READ: begin
        csr_addrr = op_addr;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        csr_addrw   = op_addr;
        csr_wdata   = alu_wdata;
        csr_we      = op_wr_en && !ill;
        rsp_valid   = 1'b1;
        rsp_rdata   = ill ? '0 : op_old;
        rsp_illegal = ill;
        state_nxt   = ST_IDLE;
      end
      ST_TWRITE: begin
        csr_we    = 1'b1;
        csr_addrw = op_addr;
        csr_wdata = op_src;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // trap writes reuse the op address/source registers; they are never live at the same time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_f3    <= '0;
      op_addr  <= '0;
      op_src   <= '0;
      op_old   <= '0;
      op_wr_en <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trap_acc) begin
        op_addr <= trap_addr;
        op_src  <= trap_wdata;
      end else if (req_acc) begin
        op_f3    <= req_funct3;
        op_addr  <= req_addr;
        op_src   <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1;
        op_wr_en <= f3_wr_always(req_funct3) || (req_rs1_idx != 5'd0);
      end
      if (state == ST_READ) op_old <= csr_rdata;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized bench for csr_access_ctrl against a CSR-file reference model.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1;
  logic [4:0]  req_rs1_idx;
  logic        trap_valid, trap_ready;
  logic [11:0] trap_addr;
  logic [31:0] trap_wdata;
  logic [11:0] csr_addrr, csr_addrw;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_we, rsp_valid, rsp_illegal, busy;
  logic [31:0] rsp_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ref_mem [0:4095];
  logic [31:0] dut_mem [0:4095];
  logic        dut_wr  [0:4095] = '{default: 1'b0};

  logic [11:0] addr_tab [0:7] = '{12'h340, 12'h341, 12'h300, 12'h305,
                                  12'hC00, 12'hC82, 12'h7C0, 12'hF11};

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1(req_rs1), .req_rs1_idx(req_rs1_idx),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_addr(trap_addr), .trap_wdata(trap_wdata),
    .csr_addrr(csr_addrr), .csr_rdata(csr_rdata),
    .csr_addrw(csr_addrw), .csr_wdata(csr_wdata), .csr_we(csr_we),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // CSR unit stand-in: combinational read, write on the clock edge
  assign csr_rdata = dut_wr[csr_addrr] ? dut_mem[csr_addrr] : init_val(csr_addrr);
  always @(posedge clk) begin
    if (csr_we) begin
      dut_mem[csr_addrw] <= csr_wdata;
      dut_wr[csr_addrw]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_idle();
    chk("idle_busy", busy, 0);
    chk("idle_we", csr_we, 0);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_addrr", csr_addrr, 0);
    chk("idle_addrw", csr_addrw, 0);
    chk("idle_wdata", csr_wdata, 0);
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] rs1, input logic [4:0] idx);
    int          kind;
    logic [31:0] old, src, newv;
    logic        writes, ill, exp_we;
    kind   = int'(f3) % 4;
    old    = ref_mem[a];
    src    = (f3 >= 3'd4) ? 32'(idx) : rs1;
    writes = (kind == 1) || (idx != 0);
    ill    = (kind == 0) || (writes && (a >= 12'hC00));
    exp_we = writes && !ill;
    case (kind)
      2:       newv = old | src;
      3:       newv = old & ~src;
      default: newv = src;
    endcase
    @(negedge clk);
    chk_idle();
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1 = rs1; req_rs1_idx = idx;
    #1 chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_funct3 = 3'($urandom); req_addr = 12'($urandom);
    req_rs1 = $urandom; req_rs1_idx = 5'($urandom);
    @(negedge clk);
    chk("rd_busy", busy, 1);
    chk("rd_addrr", csr_addrr, a);
    chk("rd_we", csr_we, 0);
    chk("rd_rsp", rsp_valid, 0);
    chk("rd_ready", req_ready, 0);
    @(negedge clk);
    chk("ex_rsp", rsp_valid, 1);
    chk("ex_ill", rsp_illegal, ill);
    chk("ex_rdata", rsp_rdata, ill ? 32'd0 : old);
    chk("ex_we", csr_we, exp_we);
    if (exp_we) begin
      chk("ex_addrw", csr_addrw, a);
      chk("ex_wdata", csr_wdata, newv);
      ref_mem[a] = newv;
    end
  endtask

  task automatic do_trap(input logic [11:0] a, input logic [31:0] d, input logic with_req,
                         input logic [2:0] f3, input logic [11:0] ra,
                         input logic [31:0] rs1, input logic [4:0] idx);
    @(negedge clk);
    chk("tr_idle", busy, 0);
    trap_valid = 1'b1; trap_addr = a; trap_wdata = d;
    if (with_req) begin
      req_valid = 1'b1; req_funct3 = f3; req_addr = ra; req_rs1 = rs1; req_rs1_idx = idx;
    end
    #1 chk("tr_ready", trap_ready, 1);
    chk("tr_req_blocked", req_ready, 0);
    @(posedge clk);
    #1 trap_valid = 1'b0; trap_addr = 12'($urandom); trap_wdata = $urandom;
    @(negedge clk);
    chk("tw_we", csr_we, 1);
    chk("tw_addrw", csr_addrw, a);
    chk("tw_wdata", csr_wdata, d);
    chk("tw_rsp", rsp_valid, 0);
    chk("tw_busy", busy, 1);
    chk("tw_req_ready", req_ready, 0);
    ref_mem[a] = d;
    if (with_req) do_req(f3, ra, rs1, idx);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    rst = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_rs1_idx = '0;
    trap_valid = 1'b0; trap_addr = '0; trap_wdata = '0;

    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_trap_ready", trap_ready, 1);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_we", csr_we, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ill", rsp_illegal, 0);
    trap_valid = 1'b1;
    #1 chk("rst_req_ready_trap", req_ready, 0);
    trap_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // pure read of a read-only counter
    do_trap(12'hC00, 32'h0000_0123, 1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    do_req(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0);
    // write to read-only counter
    do_req(3'b001, 12'hC00, 32'h5, 5'd3);
    // plain swap
    do_trap(12'h340, 32'hAAAA_0000, 1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    do_req(3'b001, 12'h340, 32'h1234_5678, 5'd7);
    // immediate set/clear
    do_req(3'b001, 12'h340, 32'h0000_00FF, 5'd7);
    do_req(3'b111, 12'h340, 32'hDEAD_BEEF, 5'h0F);
    do_req(3'b110, 12'h340, 32'hDEAD_BEEF, 5'h10);
    // trap and request in the same cycle
    do_trap(12'h341, 32'h8000_0010, 1'b1, 3'b010, 12'h341, 32'h0, 5'd0);

    // reset during READ drops the op
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h305; req_rs1 = 32'hCAFE_F00D; req_rs1_idx = 5'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", csr_we, 0);
    chk("arst_rsp", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("arst_we2", csr_we, 0);
    chk("arst_rsp2", rsp_valid, 0);
    rst = 1'b0;
    do_req(3'b000, 12'h305, 32'h1, 5'd1);
    do_req(3'b010, 12'h305, 32'h0, 5'd0);

    // randomized mix
    for (int n = 0; n < 120; n++) begin
      logic [11:0] a, ta;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [4:0]  idx;
      a   = addr_tab[$urandom_range(0, 7)];
      ta  = addr_tab[$urandom_range(0, 7)];
      f3  = 3'($urandom);
      rs1 = $urandom;
      idx = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 9) < 2)
        do_trap(ta, $urandom, 1'($urandom), f3, a, rs1, idx);
      else
        do_req(f3, a, rs1, idx);
    end

    @(negedge clk);
    chk_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
